// File: rtl/tour_cmd_pkg.sv
// tour_cmd_pkg: shared FSM states, error codes and Knight command constants for tour_cmd_player.
package tour_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_SNT, S_WAIT_RESP, S_NEXT, S_ERR} tour_state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_TIMEOUT = 2'b01, ERR_NAK = 2'b10} err_code_t;
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [3:0] OP_MOVE = 4'h4;
  localparam logic [3:0] OP_MOVE_FF = 4'h5;
  function automatic logic [15:0] move_cmd(input logic [3:0] op, input logic [7:0] heading, input logic [3:0] sqrs);
    return {op, heading, sqrs};
  endfunction
endpackage

// File: rtl/tour_cmd_mem.sv
// tour_cmd_mem: DEPTH x 16 command store, synchronous write and combinational read.
// No reset, so the stored tour survives rst; swap for a RAM macro if needed.
module tour_cmd_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [15:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [15:0]              o_rdata
);
  logic [15:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/tour_cmd_player.sv
// tour_cmd_player: replays stored Knight commands into RemoteComm, checking ack, timeout and NAK.
// Define TOUR_CMD_RETRY_EN to re-send a failed command up to MAX_RETRY times.
module tour_cmd_player
  import tour_cmd_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [15:0]              load_data,
  input  logic [$clog2(DEPTH):0]   num_cmds,
  input  logic                     start,
  output logic [15:0]              cmd,
  output logic                     snd_cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYC - 1);
  tour_state_t r_state;
  err_code_t r_code;
  logic [15:0] r_cmd, w_rdata;
  logic r_snd, r_done, r_err;
  logic [AW-1:0] r_idx;
  logic [AW:0] r_num, w_num;
  logic [CW-1:0] r_cnt;
  logic w_start, w_fail, w_can_retry, w_last;
  assign busy = r_state != S_IDLE && r_state != S_ERR;
  assign w_start = start && !busy;
  assign w_num = num_cmds > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_cmds;
  // A response in the terminal-count cycle takes priority over the timeout.
  assign w_fail = r_state == S_WAIT_RESP && (resp_rdy ? resp != POS_ACK : r_cnt == TC);
  assign w_last = {1'b0, r_idx} == r_num - 1'b1;
  assign cmd = r_cmd;
  assign snd_cmd = r_snd;
  assign done = r_done;
  assign err = r_err;
  assign err_code = r_code;
  assign cur_idx = r_idx;
  tour_cmd_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .i_we(load_we && !busy),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_raddr(r_idx),
    .o_rdata(w_rdata)
  );
`ifdef TOUR_CMD_RETRY_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry;
  always_ff @(posedge clk)
    if (rst || w_start || r_state == S_NEXT) r_retry <= '0;
    else if (w_fail && w_can_retry) r_retry <= r_retry + 1'b1;
  assign w_can_retry = r_retry < RW'(MAX_RETRY);
`else
  assign w_can_retry = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_code <= ERR_NONE;
      r_cmd <= '0;
      r_snd <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_idx <= '0;
      r_num <= '0;
      r_cnt <= '0;
    end else begin
      r_snd <= 1'b0;
      r_done <= 1'b0;
      if (r_cnt != TC) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE, S_ERR: if (start) begin
          r_err <= 1'b0;
          r_code <= ERR_NONE;
          r_idx <= '0;
          r_num <= w_num;
          r_done <= num_cmds == '0;
          r_state <= num_cmds == '0 ? S_IDLE : S_SEND;
        end
        S_SEND: begin
          r_cmd <= w_rdata;
          r_snd <= 1'b1;
          r_cnt <= '0;
          r_state <= S_WAIT_SNT;
        end
        S_WAIT_SNT: if (cmd_snt) r_state <= S_WAIT_RESP;
        S_WAIT_RESP:
          if (w_fail) begin
            if (w_can_retry) r_state <= S_SEND;
            else begin
              r_err <= 1'b1;
              r_code <= resp_rdy ? ERR_NAK : ERR_TIMEOUT;
              r_state <= S_ERR;
            end
          end else if (resp_rdy) r_state <= S_NEXT;
        S_NEXT:
          if (w_last) begin
            r_done <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_state <= S_SEND;
          end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_tour_cmd_player.sv
// tb_tour_cmd_player: scoreboard bench; a tour-level model predicts sends and the final outcome,
// a RemoteComm stand-in answers each send according to a planned outcome.
module tb_tour_cmd_player;
  import tour_cmd_pkg::*;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int TO = 100;
  localparam int MR = 2;
`ifdef TOUR_CMD_RETRY_EN
  localparam int MAXR = MR;
`else
  localparam int MAXR = 0;
`endif
  localparam int ACK = 0, NAK = 1, TMO = 2, LATE = 3;
  typedef struct {bit is_err; logic [1:0] code; int idx; bit zero;} res_t;
  logic clk = 0, rst = 1, load_we = 0, start = 0, cmd_snt = 0, resp_rdy = 0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [AW:0] num_cmds = '0;
  logic [7:0] resp = '0;
  logic [15:0] cmd;
  logic snd_cmd, busy, done, err;
  logic [1:0] err_code;
  logic [AW-1:0] cur_idx;
  int tests = 0, fails = 0, cyc = 0, last_snd = 0, acc_cyc = 0;
  logic [15:0] mem_m [DEPTH];
  logic [15:0] exp_cmd [$];
  int rplan [$];
  int forced [$];
  res_t exp_res [$];
  bit err_q = 0;

  tour_cmd_player #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .num_cmds(num_cmds), .start(start), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] rand_cmd();
    int k = $urandom_range(0, 2);
    return k == 0 ? CAL_GYRO : move_cmd(k == 1 ? OP_MOVE : OP_MOVE_FF, 8'($urandom), 4'($urandom));
  endfunction

  function automatic int pick();
    int r = $urandom_range(0, 99);
    return r < 70 ? ACK : r < 82 ? NAK : r < 90 ? TMO : LATE;
  endfunction

  task automatic check_reset(input string nm);
    chk({nm, "_cmd"}, 32'(cmd), 0);
    chk({nm, "_snd_cmd"}, 32'(snd_cmd), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_err_code"}, 32'(err_code), 0);
    chk({nm, "_cur_idx"}, 32'(cur_idx), 0);
  endtask

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    load_we = 1;
    load_addr = AW'(a);
    load_data = d;
    @(negedge clk);
    load_we = 0;
    mem_m[a] = d;
  endtask

  // Tour-level model: walk the slots, consume one planned outcome per send.
  task automatic run_tour(input int n_req, input bit sl);
    int n, tries, o, t;
    bit fin;
    logic [15:0] sv;
    res_t r;
    n = n_req > DEPTH ? DEPTH : n_req;
    fin = 0;
    sv = rand_cmd();
    if (sl) mem_m[0] = sv;
    for (int i = 0; i < n && !fin; i++) begin
      tries = 0;
      forever begin
        o = forced.size() != 0 ? forced.pop_front() : pick();
        exp_cmd.push_back(mem_m[i]);
        rplan.push_back(o);
        if (o == ACK || o == LATE) break;
        if (tries < MAXR) tries++;
        else begin
          r.is_err = 1; r.code = o == NAK ? 2'b10 : 2'b01; r.idx = i; r.zero = 0;
          exp_res.push_back(r);
          fin = 1;
          break;
        end
      end
    end
    if (!fin) begin
      r.is_err = 0; r.code = 2'b00; r.idx = n - 1; r.zero = n == 0;
      exp_res.push_back(r);
    end
    forced.delete();
    @(negedge clk);
    num_cmds = (AW+1)'(n_req);
    start = 1;
    if (sl) begin load_we = 1; load_addr = '0; load_data = sv; end
    @(negedge clk);
    start = 0;
    load_we = 0;
    if (n > 0) begin
      @(negedge clk);
      start = 1;
      load_we = 1;
      load_addr = AW'($urandom);
      load_data = 16'($urandom);
      num_cmds = (AW+1)'($urandom);
      @(negedge clk);
      start = 0;
      load_we = 0;
    end
    t = 0;
    while (exp_res.size() != 0 && t < 20000) begin @(negedge clk); t++; end
    chk("tour_outcome_seen", exp_res.size(), 0);
    exp_res.delete();
    repeat (3) @(negedge clk);
    chk("tour_sends_left", exp_cmd.size(), 0);
    chk("tour_busy_after", 32'(busy), 0);
    exp_cmd.delete();
    rplan.delete();
  endtask

  // RemoteComm stand-in: cmd_snt after a few cycles, then the planned response.
  initial begin
    int o, d1;
    logic [7:0] nv;
    forever begin
      @(negedge clk);
      cmd_snt = 0;
      resp_rdy = 0;
      if (snd_cmd && !rst) begin
        o = rplan.size() != 0 ? rplan.pop_front() : TMO;
        d1 = $urandom_range(1, 4);
        repeat (d1) @(negedge clk);
        cmd_snt = 1;
        if (o == ACK && $urandom_range(0, 1) == 1) begin resp_rdy = 1; resp = 8'h00; end
        @(negedge clk);
        cmd_snt = 0;
        resp_rdy = 0;
        if (o == ACK || o == NAK) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          do nv = 8'($urandom); while (nv == POS_ACK);
          resp_rdy = 1;
          resp = o == ACK ? POS_ACK : nv;
        end else if (o == LATE) begin
          repeat (TO - 2 - d1) @(negedge clk);
          resp_rdy = 1;
          resp = POS_ACK;
        end
      end
    end
  end

  always @(posedge clk)
    if (!rst && start && !busy) acc_cyc = cyc;

  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (snd_cmd) begin
          last_snd = cyc;
          if (exp_cmd.size() == 0) chk("unexpected_snd_cmd", 32'(snd_cmd), 0);
          else chk("snd_cmd_word", 32'(cmd), 32'(exp_cmd.pop_front()));
        end
        if (done) begin
          if (exp_res.size() == 0) chk("unexpected_done", 32'(done), 0);
          else begin
            r = exp_res.pop_front();
            chk("result_kind", 32'({err, done}), r.is_err ? 2 : 1);
            chk("busy_at_done", 32'(busy), 0);
            if (r.zero) chk("zero_done_latency", cyc - acc_cyc, 1);
            else chk("done_cur_idx", 32'(cur_idx), r.idx);
          end
        end
        if (err && !err_q) begin
          if (exp_res.size() == 0) chk("unexpected_err", 32'(err), 0);
          else begin
            r = exp_res.pop_front();
            chk("result_kind", 32'({err, done}), r.is_err ? 2 : 1);
            chk("err_code", 32'(err_code), 32'(r.code));
            chk("err_cur_idx", 32'(cur_idx), r.idx);
            if (r.code == 2'b01) chk("timeout_latency", cyc - last_snd, TO);
          end
        end
      end
      err_q = err;
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 0;
    for (int a = 0; a < DEPTH; a++) load(a, rand_cmd());
    load(0, CAL_GYRO);
    load(1, 16'h43F2);
    load(2, 16'h5001);
    forced = '{ACK, ACK, ACK};
    run_tour(3, 0);
    run_tour(0, 0);
    forced = '{TMO, TMO, TMO};
    run_tour(1, 0);
    forced = '{ACK, NAK, NAK, ACK, ACK};
    run_tour(3, 0);
    forced = '{LATE};
    run_tour(1, 0);
    exp_cmd.push_back(mem_m[0]);
    exp_cmd.push_back(mem_m[1]);
    rplan.push_back(ACK);
    rplan.push_back(TMO);
    @(negedge clk);
    num_cmds = 3;
    start = 1;
    @(negedge clk);
    start = 0;
    t = 0;
    while (exp_cmd.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    chk("rst_setup_sends", exp_cmd.size(), 0);
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset("mid_rst");
    rst = 0;
    exp_cmd.delete();
    rplan.delete();
    repeat (150) @(negedge clk);
    forced = '{ACK, ACK, ACK};
    run_tour(3, 0);
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) load($urandom_range(0, DEPTH - 1), rand_cmd());
      run_tour($urandom_range(0, 2 * DEPTH - 1), $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
